icache: RTL and testbench



---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_ram.sv | 47 ++++
 rtl/icache.sv | 134 +++++++++++++
 tb/tb_icache.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    localparam int INST_ADDR_W       = 32;   // InstAddrBus
    localparam int INST_W            = 32;   // InstBus
    localparam int ICACHE_INDEX_BITS = 7;    // ICacheIndexBits
    localparam int ICACHE_ADDR_BITS  = 18;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    // The top quarter of the RAM-visible address space is I/O and never cached.
    localparam logic [1:0] IO_REGION = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_e;

endpackage

// File: rtl/icache_ram.sv
// Tag, valid and data storage: combinational read port, synchronous write port.
module icache_ram #(
    parameter int INDEX_BITS = 7,
    parameter int TAG_W      = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [DATA_W-1:0]     rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [DATA_W-1:0]     wr_data_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits gate them, and an
    // unreset array can map onto RAM instead of flops.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and the memory controller.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int ADDR_BITS  = ICACHE_ADDR_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [INST_ADDR_W-1:0] if_addr,
    output logic                   if_done,
    output logic [INST_W-1:0]      if_inst,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic                   mc_req,
    output logic [INST_ADDR_W-1:0] mc_addr,
    input  logic                   mc_done,
    input  logic [INST_W-1:0]      mc_inst,
    input  logic [INST_ADDR_W-1:0] mc_pc
);

    localparam int TAG_W = ADDR_BITS - INDEX_BITS - 2;

    state_e                 state_q,   state_d;
    logic                   if_done_q, if_done_d;
    logic [INST_W-1:0]      if_inst_q, if_inst_d;
    logic [INST_ADDR_W-1:0] if_pc_q,   if_pc_d;
    logic                   mc_req_q,  mc_req_d;
    logic [INST_ADDR_W-1:0] mc_addr_q, mc_addr_d;

    logic                   rd_valid;
    logic [TAG_W-1:0]       rd_tag;
    logic [INST_W-1:0]      rd_data;
    logic                   wr_en;

    logic [INDEX_BITS-1:0]  lk_idx;
    logic [TAG_W-1:0]       lk_tag;
    logic                   lk_cacheable;
    logic                   fill_cacheable;
    logic                   hit;
    logic                   repeat_fetch;
    logic                   fill_ok;

    assign lk_idx         = if_addr[INDEX_BITS+1:2];
    assign lk_tag         = if_addr[ADDR_BITS-1:INDEX_BITS+2];
    assign lk_cacheable   = (if_addr[ADDR_BITS-1:ADDR_BITS-2] != IO_REGION);
    assign fill_cacheable = (mc_addr_q[ADDR_BITS-1:ADDR_BITS-2] != IO_REGION);
    assign hit            = rd_valid && (rd_tag == lk_tag) && lk_cacheable;

    // IF still shows the answered request during the if_done cycle; don't serve it twice.
    assign repeat_fetch   = if_done_q && (if_addr == if_pc_q);
    assign fill_ok        = (state_q == MISS) && mc_done && (mc_pc == mc_addr_q);
    assign wr_en          = fill_ok && fill_cacheable && !rst;

    icache_ram #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .DATA_W     (INST_W)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (lk_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (mc_addr_q[INDEX_BITS+1:2]),
        .wr_tag_i   (mc_addr_q[ADDR_BITS-1:INDEX_BITS+2]),
        .wr_data_i  (mc_inst)
    );

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        if_done_d = 1'b0;
        if_inst_d = if_inst_q;
        if_pc_d   = if_pc_q;
        mc_req_d  = mc_req_q;
        mc_addr_d = mc_addr_q;
        case (state_q)
            IDLE: begin
                if (if_req && !repeat_fetch) begin
                    if (hit) begin
                        if_done_d = 1'b1;
                        if_inst_d = rd_data;
                        if_pc_d   = if_addr;
                    end else begin
                        state_d   = MISS;
                        mc_req_d  = 1'b1;
                        mc_addr_d = if_addr;
                    end
                end
            end
            MISS: begin
                if (fill_ok) begin
                    state_d  = IDLE;
                    mc_req_d = 1'b0;
                    // A redirected IF gets nothing here; it is served from IDLE instead.
                    if (if_req && (if_addr == mc_addr_q)) begin
                        if_done_d = 1'b1;
                        if_inst_d = mc_inst;
                        if_pc_d   = mc_pc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            if_done_q <= 1'b0;
            if_inst_q <= ZERO_WORD;
            if_pc_q   <= '0;
            mc_req_q  <= 1'b0;
            mc_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            if_done_q <= if_done_d;
            if_inst_q <= if_inst_d;
            if_pc_q   <= if_pc_d;
            mc_req_q  <= mc_req_d;
            mc_addr_q <= mc_addr_d;
        end
    end

    assign if_done = if_done_q;
    assign if_inst = if_inst_q;
    assign if_pc   = if_pc_q;
    assign mc_req  = mc_req_q;
    assign mc_addr = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: vector table, scoreboard of expected IF responses, corner sequences.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_inst;
    logic [31:0] mc_pc;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    icache dut (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_done (if_done),
        .if_inst (if_inst),
        .if_pc   (if_pc),
        .mc_req  (mc_req),
        .mc_addr (mc_addr),
        .mc_done (mc_done),
        .mc_inst (mc_inst),
        .mc_pc   (mc_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_0513;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every if_done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && if_done === 1'b1) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_if_done: got if_pc=%h, expected no response", if_pc);
            end else begin
                e = exp_q.pop_front();
                check("if_inst", if_inst, e.inst);
                check("if_pc", if_pc, e.pc);
            end
        end
    end

    task automatic idle();
        if_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_mc(input logic [31:0] pc, input logic [31:0] inst);
        mc_done = 1'b1;
        mc_pc   = pc;
        mc_inst = inst;
        @(posedge clk); #1;
        mc_done = 1'b0;
    endtask

    task automatic serve(input logic [31:0] a, input int lat);
        repeat (lat) begin
            @(posedge clk); #1;
        end
        check("mc_req_held", {31'b0, mc_req}, 32'd1);
        check("mc_addr_stable", mc_addr, a);
        pulse_mc(a, mem_word(a));
    endtask

    // Returns in the cycle if_done is visible, with if_req still high on addr a.
    task automatic fetch(input logic [31:0] a, input bit exp_miss, input int lat);
        bit missed = 1'b0;
        bit got    = 1'b0;
        int n      = 0;
        if_req  = 1'b1;
        if_addr = a;
        exp_q.push_back('{inst: mem_word(a), pc: a});
        while (!got && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (mc_req && !missed) begin
                missed = 1'b1;
                check("mc_addr", mc_addr, a);
                serve(a, lat);
            end
            if (if_done) got = 1'b1;
        end
        check("fetch_done_seen", {31'b0, got}, 32'd1);
        check("fetch_missed", {31'b0, missed}, {31'b0, exp_miss});
        if (!exp_miss) check("hit_latency", n, 32'd1);
    endtask

    task automatic wait_mc_req(input logic [31:0] a);
        int n = 0;
        while (!mc_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("mc_req_seen", {31'b0, mc_req}, 32'd1);
        check("mc_addr_req", mc_addr, a);
    endtask

    initial begin
        rst     = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        mc_done = 1'b0;
        mc_inst = '0;
        mc_pc   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_if_done", {31'b0, if_done}, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_mc_req", {31'b0, mc_req}, 32'd0);
        check("rst_mc_addr", mc_addr, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Cold fill, aliasing, neighbours, uncacheable I/O, highest index.
        vecs.push_back('{addr: 32'h0000_0000, miss: 1'b1, lat: 4});
        vecs.push_back('{addr: 32'h0000_0000, miss: 1'b0, lat: 0});
        vecs.push_back('{addr: 32'h0000_0200, miss: 1'b1, lat: 2});
        vecs.push_back('{addr: 32'h0000_0200, miss: 1'b0, lat: 0});
        vecs.push_back('{addr: 32'h0000_0000, miss: 1'b1, lat: 1});
        vecs.push_back('{addr: 32'h0000_0004, miss: 1'b1, lat: 0});
        vecs.push_back('{addr: 32'h0000_0008, miss: 1'b1, lat: 3});
        vecs.push_back('{addr: 32'h0000_0004, miss: 1'b0, lat: 0});
        vecs.push_back('{addr: 32'h0003_0000, miss: 1'b1, lat: 2});
        vecs.push_back('{addr: 32'h0003_0000, miss: 1'b1, lat: 2});
        vecs.push_back('{addr: 32'h0000_0000, miss: 1'b0, lat: 0});
        vecs.push_back('{addr: 32'h0003_FFFC, miss: 1'b1, lat: 1});
        vecs.push_back('{addr: 32'h0001_FFFC, miss: 1'b1, lat: 1});
        vecs.push_back('{addr: 32'h0001_FFFC, miss: 1'b0, lat: 0});
        vecs.push_back('{addr: 32'h0003_FFFC, miss: 1'b1, lat: 0});
        foreach (vecs[i]) begin
            fetch(vecs[i].addr, vecs[i].miss, vecs[i].lat);
            idle();
        end

        // Back-to-back hits on distinct addresses: if_done on consecutive cycles.
        fetch(32'h0000_0004, 1'b0, 0);
        fetch(32'h0000_0008, 1'b0, 0);
        fetch(32'h0000_0000, 1'b0, 0);
        // IF holding the answered request one more cycle must not get a second if_done.
        @(posedge clk); #1;
        check("no_double_done", {31'b0, if_done}, 32'd0);
        idle();

        // Redirect during MISS with a mismatched mc_pc pulse first.
        if_req  = 1'b1;
        if_addr = 32'h0000_0010;
        wait_mc_req(32'h0000_0010);
        if_addr = 32'h0000_0040;
        @(posedge clk); #1;
        check("redirect_mc_addr", mc_addr, 32'h0000_0010);
        pulse_mc(32'h0000_0014, 32'hDEAD_BEEF);
        check("pc_mismatch_ignored", {31'b0, mc_req}, 32'd1);
        pulse_mc(32'h0000_0010, mem_word(32'h0000_0010));
        check("redirect_no_done", {31'b0, if_done}, 32'd0);
        check("redirect_mc_req_drop", {31'b0, mc_req}, 32'd0);
        fetch(32'h0000_0040, 1'b1, 2);
        idle();
        fetch(32'h0000_0010, 1'b0, 0);
        idle();
        fetch(32'h0000_0014, 1'b1, 1);
        idle();

        // mc_done while IDLE must not allocate.
        pulse_mc(32'h0000_0080, 32'hBAD0_0080);
        fetch(32'h0000_0080, 1'b1, 1);
        idle();

        // Reset in the middle of a miss, then a late mc_done.
        fetch(32'h0000_0020, 1'b1, 1);
        idle();
        if_req  = 1'b1;
        if_addr = 32'h0000_0024;
        wait_mc_req(32'h0000_0024);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_miss_mc_req", {31'b0, mc_req}, 32'd0);
        rst    = 1'b0;
        if_req = 1'b0;
        @(posedge clk); #1;
        pulse_mc(32'h0000_0024, mem_word(32'h0000_0024));
        check("late_mc_done_no_req", {31'b0, mc_req}, 32'd0);
        check("late_mc_done_no_done", {31'b0, if_done}, 32'd0);
        fetch(32'h0000_0020, 1'b1, 1);
        idle();
        fetch(32'h0000_0024, 1'b1, 1);
        idle();
        idle();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
